// File: rtl/ntt_seq_pkg.sv
// ntt_seq_pkg: shared state type and sizing helpers
// for the NTT stage sequencer.
package ntt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

  // Base of stage s in the stage-concatenated twiddle table
  function automatic int tw_base(input int s);
    return (1 << s) - 1;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// ntt_wb_delay: fixed-latency writeback delay line of
// {valid, idx} with synchronous clear and drain flag.
module ntt_wb_delay
  import ntt_seq_pkg::*;
#(
  parameter int LAT = 4,
  parameter int IW  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [IW-1:0] in_idx,
  output logic          out_vld,
  output logic [IW-1:0] out_idx,
  output logic          empty
);

  logic [LAT-1:0] vld_q;
  logic [IW-1:0]  idx_q [LAT];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vld_q <= '0;
      for (int k = 0; k < LAT; k++) idx_q[k] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        idx_q[k] <= idx_q[k-1];
      end
    end
  end

  // The output slot is retiring now, so it does not count
  always_comb begin
    empty = 1'b1;
    for (int k = 0; k < LAT - 1; k++) begin
      if (vld_q[k]) empty = 1'b0;
    end
  end

  assign out_vld = vld_q[LAT-1];
  assign out_idx = idx_q[LAT-1];

endmodule

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: NTT stage sequencer (issue, drain, bank swap).
// Define NTT_SEQ_PERF_EN to build the cycle/stall counters.
module ntt_seq_ctrl
  import ntt_seq_pkg::*;
#(
  parameter int N       = 256,
  parameter int LOG_N   = log2c(N),
  parameter int BFU_LAT = 4,
  localparam int IW     = LOG_N - 1,
  localparam int SW     = log2c(LOG_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [SW-1:0]    stage,
  output logic             bfu_en,
  output logic [IW-1:0]    rd_idx,
  output logic             rd_bank,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [IW-1:0]    wr_idx,
  output logic             res_bank,
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls
);

  localparam logic [IW-1:0] I_LAST = IW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG_N - 1);

  seq_state_t    state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          bank_q, bank_d;
  logic          res_q, res_d;
  logic          wb_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      stage_q <= '0;
      bank_q  <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      stage_q <= stage_d;
      bank_q  <= bank_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    stage_d = stage_q;
    bank_d  = bank_q;
    res_d   = res_q;
    bfu_en  = (state_q == RUN) && !stall;
    done    = (state_q == DONE) && !abort;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d = RUN;
          i_d     = '0;
          stage_d = '0;
          bank_d  = 1'b0;
        end
        RUN: if (!stall) begin
          i_d = i_q + IW'(1);
          if (i_q == I_LAST) state_d = DRAIN;
        end
        DRAIN: if (wb_empty) begin
          if (stage_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
            bank_d  = ~bank_q;
          end
        end
        DONE: begin
          state_d = IDLE;
          res_d   = ~bank_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign stage    = stage_q;
  assign rd_idx   = i_q;
  assign rd_bank  = bank_q;
  assign res_bank = res_q;
  assign tw_addr  = LOG_N'(tw_base(int'(stage_q)))
                  + (LOG_N'(i_q) >> (IW - int'(stage_q)));

  ntt_wb_delay #(
    .LAT (BFU_LAT),
    .IW  (IW)
  ) u_wb (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (abort),
    .in_vld  (bfu_en),
    .in_idx  (i_q),
    .out_vld (wr_en),
    .out_idx (wr_idx),
    .empty   (wb_empty)
  );

`ifdef NTT_SEQ_PERF_EN
  logic [31:0] cyc_q, stl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else if (state_q == IDLE && start && !abort) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else begin
      if (busy && cyc_q != '1) cyc_q <= cyc_q + 32'd1;
      if (state_q == RUN && stall && stl_q != '1)
        stl_q <= stl_q + 32'd1;
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stalls = stl_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb_ntt_seq_ctrl: schedule-model checker for ntt_seq_ctrl
// with N=256, BFU_LAT=4.
module tb_ntt_seq_ctrl;

  localparam int N     = 256;
  localparam int LOG_N = 8;
  localparam int LAT   = 4;
  localparam int NC    = 1500;

  logic        clk = 1'b0;
  logic        rst_n, start, stall, abort;
  logic        busy, done, bfu_en, rd_bank;
  logic        wr_en, res_bank;
  logic [2:0]  stage;
  logic [6:0]  rd_idx, wr_idx;
  logic [7:0]  tw_addr;
  logic [31:0] perf_cycles, perf_stalls;

  always #5 clk = ~clk;

  ntt_seq_ctrl #(.N(N), .BFU_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stall       (stall),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .stage       (stage),
    .bfu_en      (bfu_en),
    .rd_idx      (rd_idx),
    .rd_bank     (rd_bank),
    .tw_addr     (tw_addr),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .res_bank    (res_bank),
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
  );

  int errs = 0;
  int checks = 0;

  // Expected schedule, indexed by cycle since start
  bit m_busy[NC], m_done[NC], m_run[NC];
  bit m_bfu[NC], m_wr[NC], stall_v[NC];
  int m_stage[NC], m_idx[NC], m_tw[NC], m_widx[NC];

  int cyc, scen;
  bit chk_en = 1'b0;
  int n_bfu, n_wr, n_done, done_at;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d",
               nm, cyc, act, exp);
    end
  endtask

  function automatic void clear_model();
    for (int k = 0; k < NC; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_run[k] = 0;
      m_bfu[k] = 0; m_wr[k] = 0; stall_v[k] = 0;
      m_stage[k] = 0; m_idx[k] = 0;
      m_tw[k] = 0; m_widx[k] = 0;
    end
  endfunction

  function automatic void mark(int c, int lim, int s,
                               int i, bit run, bit en);
    if (c > lim) return;
    m_busy[c] = 1;
    m_stage[c] = s;
    m_run[c] = run;
    m_bfu[c] = en;
    m_idx[c] = i;
    m_tw[c] = ((1 << s) - 1) + (i >> (LOG_N - 1 - s));
  endfunction

  // One transform started at s0; ab>=0 cuts it off after cycle ab
  function automatic void add_xfer(int s0, int ab);
    int c, lim;
    c = s0 + 1;
    lim = (ab < 0) ? NC - 1 : ab;
    for (int s = 0; s < LOG_N; s++) begin
      for (int i = 0; i < N / 2; i++) begin
        while (stall_v[c]) begin
          mark(c, lim, s, i, 1, 0);
          c++;
        end
        mark(c, lim, s, i, 1, 1);
        if (c + LAT <= lim) begin
          m_wr[c + LAT] = 1;
          m_widx[c + LAT] = i;
        end
        c++;
      end
      for (int d = 0; d < LAT; d++) begin
        mark(c, lim, s, 0, 0, 0);
        c++;
      end
    end
    if (c <= lim) begin
      mark(c, lim, LOG_N - 1, 0, 0, 0);
      m_done[c] = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy[cyc]);
      chk("done", done, m_done[cyc]);
      chk("bfu_en", bfu_en, m_bfu[cyc]);
      chk("wr_en", wr_en, m_wr[cyc]);
      if (m_busy[cyc]) begin
        chk("stage", stage, m_stage[cyc]);
        chk("rd_bank", rd_bank, m_stage[cyc] % 2);
      end
      if (m_run[cyc]) begin
        chk("rd_idx", rd_idx, m_idx[cyc]);
        chk("tw_addr", tw_addr, m_tw[cyc]);
      end
      if (m_wr[cyc]) chk("wr_idx", wr_idx, m_widx[cyc]);
      if (bfu_en) n_bfu++;
      if (wr_en) n_wr++;
      if (done) begin
        n_done++;
        done_at = cyc;
      end
      if (scen == 1 && cyc == 50)
        chk("tw_s0", tw_addr, 0);
      if (scen == 1 && cyc == 434) begin
        chk("tw_s3_i37", tw_addr, 9);
        chk("idx_s3_i37", rd_idx, 37);
      end
      if (scen == 1 && cyc == 1052)
        chk("tw_s7_i127", tw_addr, 254);
      if (scen == 2 && cyc == 332) begin
        chk("inflight_wr", wr_en, 1);
        chk("inflight_idx", wr_idx, 63);
      end
      if (scen == 2 && cyc == 333) begin
        chk("stall_idx", rd_idx, 64);
        chk("stall_bfu", bfu_en, 0);
      end
      if (scen == 4 && cyc == 301) begin
        chk("abort_busy", busy, 0);
        chk("abort_wr", wr_en, 0);
      end
      if (scen == 5 && cyc == 3)
        chk("st_ab_busy", busy, 0);
    end
  end

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_scen(input int sc, input int ncyc,
                          input int sb, input int ab);
    scen = sc;
    n_bfu = 0;
    n_wr = 0;
    n_done = 0;
    done_at = -1;
    do_reset();
    for (int k = 0; k < ncyc; k++) begin
      cyc = k;
      start = (k == 0) || (k == sb);
      abort = (k == ab);
      stall = stall_v[k];
      chk_en = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
  endtask

  task automatic chk_perf(input int c, input int s);
`ifdef NTT_SEQ_PERF_EN
    chk("perf_cycles", perf_cycles, c);
    chk("perf_stalls", perf_stalls, s);
`else
    chk("perf_cycles", perf_cycles, 0);
    chk("perf_stalls", perf_stalls, 0);
`endif
  endtask

  initial begin
    cyc = 0;
    scen = 0;
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage, 0);
    chk("rst_bfu", bfu_en, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_rd_bank", rd_bank, 0);
    chk("rst_tw", tw_addr, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_res", res_bank, 0);
    chk_perf(0, 0);

    clear_model();
    add_xfer(0, -1);
    run_scen(1, 1060, -1, -1);
    chk("s1_done_at", done_at, 1057);
    chk("s1_n_done", n_done, 1);
    chk("s1_n_bfu", n_bfu, 1024);
    chk("s1_n_wr", n_wr, 1024);
    chk("s1_res_bank", res_bank, 0);
    chk_perf(1057, 0);

    clear_model();
    for (int k = 329; k < 339; k++) stall_v[k] = 1;
    add_xfer(0, -1);
    run_scen(2, 1070, -1, -1);
    chk("s2_done_at", done_at, 1067);
    chk("s2_n_bfu", n_bfu, 1024);
    chk_perf(1067, 10);

    clear_model();
    add_xfer(0, -1);
    run_scen(3, 1060, 500, -1);
    chk("s3_done_at", done_at, 1057);
    chk("s3_n_done", n_done, 1);

    clear_model();
    add_xfer(0, 300);
    add_xfer(305, -1);
    run_scen(4, 1366, 305, 300);
    chk("s4_n_done", n_done, 1);
    chk("s4_done_at", done_at, 1362);
    chk("s4_res_bank", res_bank, 0);

    clear_model();
    run_scen(5, 6, -1, 0);
    chk("s5_n_done", n_done, 0);
    chk("s5_n_bfu", n_bfu, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
